// File: rtl/value_uart_reporter.sv
// Watches a 6-bit counter value and reports every change over a UART 8N1 line
// as two uppercase hex digits plus a line feed, with a one-deep pending slot.
module value_uart_reporter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] value,
  output logic       tx,
  output logic       busy,
  output logic [7:0] drop_count
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nxt;
  logic [15:0] baud_cnt, baud_nxt;
  logic [2:0]  bit_cnt, bit_nxt;
  logic [1:0]  char_idx, char_nxt;
  logic [5:0]  frame_val, frame_nxt;
  logic [7:0]  char_q, char_q_nxt;
  logic [5:0]  value_q;
  logic [5:0]  pending_val;
  logic        pending_valid;
  logic        tx_nxt;

  logic        change, bit_end, frame_done, take_pending, launch;
  logic [5:0]  launch_val;

  function automatic logic [7:0] char_of(input logic [5:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h30 + {6'd0, v[5:4]};
      2'd1:    return (v[3:0] < 4'd10) ? 8'h30 + {4'd0, v[3:0]} : 8'h37 + {4'd0, v[3:0]};
      default: return 8'h0A;
    endcase
  endfunction

  assign change       = (value != value_q);
  assign bit_end      = (baud_cnt == 16'(CLKS_PER_BIT - 1));
  assign frame_done   = (state == STOP) && bit_end && (char_idx == 2'd2);
  assign take_pending = pending_valid && ((state == IDLE) || frame_done);
  // A change in the final stop cycle chains straight into the next frame.
  assign launch       = take_pending || (frame_done && change);
  assign launch_val   = pending_valid ? pending_val : value;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud_cnt;
    bit_nxt    = bit_cnt;
    char_nxt   = char_idx;
    frame_nxt  = frame_val;
    char_q_nxt = char_q;
    case (state)
      IDLE: begin
        if (launch) begin
          state_nxt  = START;
          baud_nxt   = '0;
          bit_nxt    = '0;
          char_nxt   = '0;
          frame_nxt  = launch_val;
          char_q_nxt = char_of(launch_val, 2'd0);
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          baud_nxt  = '0;
          bit_nxt   = '0;
        end else begin
          baud_nxt = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_cnt == 3'd7) state_nxt = STOP;
          else                 bit_nxt   = bit_cnt + 3'd1;
        end else begin
          baud_nxt = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_nxt = '0;
          bit_nxt  = '0;
          if (char_idx != 2'd2) begin
            state_nxt  = START;
            char_nxt   = char_idx + 2'd1;
            char_q_nxt = char_of(frame_val, char_idx + 2'd1);
          end else if (launch) begin
            state_nxt  = START;
            char_nxt   = '0;
            frame_nxt  = launch_val;
            char_q_nxt = char_of(launch_val, 2'd0);
          end else begin
            state_nxt = IDLE;
            char_nxt  = '0;
          end
        end else begin
          baud_nxt = baud_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx is registered from the next state so the line never glitches.
  always_comb begin
    tx_nxt = 1'b1;
    if (state_nxt == START)     tx_nxt = 1'b0;
    else if (state_nxt == DATA) tx_nxt = char_q_nxt[bit_nxt];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      char_idx  <= '0;
      frame_val <= '0;
      char_q    <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      char_idx  <= char_nxt;
      frame_val <= frame_nxt;
      char_q    <= char_q_nxt;
      tx        <= tx_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q       <= '0;
      pending_val   <= '0;
      pending_valid <= 1'b0;
      drop_count    <= '0;
    end else begin
      value_q <= value;
      if (change) begin
        pending_val <= value;
        // Launching directly from value leaves nothing pending.
        pending_valid <= !(launch && !pending_valid);
        if (pending_valid && !take_pending && (drop_count != 8'hFF))
          drop_count <= drop_count + 8'd1;
      end else if (take_pending) begin
        pending_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_value_uart_reporter.sv
// Directed bench for value_uart_reporter: decodes tx with a UART receiver and
// checks characters, launch latency, busy length, drop counting and reset.
module tb_value_uart_reporter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] value;
  logic       tx;
  logic       busy;
  logic [7:0] drop_count;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] rx_q[$];
  logic       rx_busy;
  int         rx_cnt;
  logic [7:0] rx_byte;
  int         rx_frame_err = 0;
  int         busy_run = 0;
  int         last_run = 0;

  value_uart_reporter #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .reset(reset), .value(value),
    .tx(tx), .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // UART receiver sampling at negedges: start at offset 0, data bit j at 4*(j+1), stop at 36.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      rx_busy <= 1'b0;
      rx_cnt  <= 0;
    end else if (!rx_busy) begin
      if (!tx) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if ((rx_cnt % N == 0) && (rx_cnt <= 8 * N))
        rx_byte[rx_cnt / N - 1] <= tx;
      if (rx_cnt == 9 * N) begin
        rx_busy <= 1'b0;
        rx_q.push_back(rx_byte);
        if (!tx) rx_frame_err <= rx_frame_err + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (busy) busy_run <= busy_run + 1;
    else begin
      if (busy_run != 0) last_run <= busy_run;
      busy_run <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rx_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hxx;
  endfunction

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [7:0] c0, input logic [7:0] c1);
    check({tag, "_c0"}, 32'(rx_at(base)),     32'(c0));
    check({tag, "_c1"}, 32'(rx_at(base + 1)), 32'(c1));
    check({tag, "_lf"}, 32'(rx_at(base + 2)), 32'h0A);
  endtask

  // Drive a change, check launch latency, frame length and decoded characters.
  task automatic send_value(input string tag, input logic [5:0] v, input logic [7:0] c0, input logic [7:0] c1);
    rx_q.delete();
    @(negedge clk) value = v;
    @(negedge clk);
    check({tag, "_pre"}, 32'({tx, busy}), 32'b10);
    @(negedge clk);
    check({tag, "_launch"}, 32'({tx, busy}), 32'b01);
    wait_idle(tag);
    check({tag, "_busylen"}, 32'(last_run), 32'd120);
    check({tag, "_nchars"}, 32'(rx_q.size()), 32'd3);
    check_frame(tag, 0, c0, c1);
  endtask

  initial begin
    reset = 1'b0;
    value = 6'h00;
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({tx, busy, drop_count}), 32'h200);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("zero_idle", 32'({tx, busy, drop_count}), 32'h200);
    check("zero_nochars", 32'(rx_q.size()), 32'd0);

    send_value("v2b", 6'h2B, 8'h32, 8'h42);
    send_value("v3f", 6'h3F, 8'h33, 8'h46);
    send_value("v09", 6'h09, 8'h30, 8'h39);
    check("drop_none", 32'(drop_count), 32'd0);

    // Two changes during one frame: one dropped, second frame chains on.
    rx_q.delete();
    @(negedge clk) value = 6'h01;
    @(negedge clk);
    @(negedge clk);
    check("chain_launch", 32'({tx, busy}), 32'b01);
    repeat (20) @(negedge clk);
    value = 6'h05;
    repeat (20) @(negedge clk);
    value = 6'h06;
    wait_idle("chain");
    check("chain_drop", 32'(drop_count), 32'd1);
    check("chain_busylen", 32'(last_run), 32'd240);
    check("chain_nchars", 32'(rx_q.size()), 32'd6);
    check_frame("chain_f0", 0, 8'h30, 8'h31);
    check_frame("chain_f1", 3, 8'h30, 8'h36);

    // Reset during data bits of the second character.
    rx_q.delete();
    @(negedge clk) value = 6'h12;
    @(negedge clk);
    @(negedge clk);
    repeat (50) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1 check("midrst_async", 32'({tx, busy, drop_count}), 32'h200);
    repeat (2) @(negedge clk);
    rx_q.delete();
    reset = 1'b1;
    @(negedge clk);
    check("midrst_pre", 32'({tx, busy}), 32'b10);
    @(negedge clk);
    check("midrst_launch", 32'({tx, busy}), 32'b01);
    wait_idle("midrst");
    check("midrst_busylen", 32'(last_run), 32'd120);
    check("midrst_nchars", 32'(rx_q.size()), 32'd3);
    check_frame("midrst", 0, 8'h31, 8'h32);

    // 300 back-to-back changes: drops saturate, four frames run continuously.
    rx_q.delete();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk) value = (i % 2 == 1) ? 6'h2A : 6'h15;
    end
    wait_idle("storm");
    check("storm_drop_sat", 32'(drop_count), 32'd255);
    check("storm_busylen", 32'(last_run), 32'd480);
    check("storm_nchars", 32'(rx_q.size()), 32'd12);
    for (int f = 0; f < 4; f++) begin
      logic ok;
      ok = ((rx_at(3*f) == 8'h31) && (rx_at(3*f+1) == 8'h35) && (rx_at(3*f+2) == 8'h0A)) ||
           ((rx_at(3*f) == 8'h32) && (rx_at(3*f+1) == 8'h41) && (rx_at(3*f+2) == 8'h0A));
      check($sformatf("storm_frame%0d", f), 32'(ok), 32'd1);
    end
    check_frame("storm_last", 9, 8'h32, 8'h41);

    check("stop_bits", 32'(rx_frame_err), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
